// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding and owner identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_LDR = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between CPU and loader requests.
// Round-robin tie breaking when MEM_ARB_RR_EN is defined, otherwise CPU has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   ldr_req,
  input  owner_t last_own,
  output logic   any_req,
  output owner_t winner
);

  assign any_req = cpu_req | ldr_req;

  // With no request the winner is a don't-care; holding the pointer keeps it stable.
  always_comb begin
    winner = last_own;
    if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last_own == OWN_CPU) ? OWN_LDR : OWN_CPU;
`else
      winner = OWN_CPU;
`endif
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else if (ldr_req) begin
      winner = OWN_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single synchronous RAM port between the CPU and the program loader.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build gives the CPU fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  arb_state_t        state;
  owner_t            owner;
  owner_t            last_own;
  owner_t            winner;
  logic              any_req;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  arb_pick u_pick (
    .cpu_req  (cpu_req),
    .ldr_req  (ldr_req),
    .last_own (last_own),
    .any_req  (any_req),
    .winner   (winner)
  );

`ifdef MEM_ARB_RR_EN
  // Reset to "loader last" so the CPU wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_own <= OWN_LDR;
    end else if (state == IDLE && any_req) begin
      last_own <= winner;
    end
  end
`else
  assign last_own = OWN_LDR;
`endif

  // Every output except read data is a register, so req never reaches an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      ram_write  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      ram_write  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            state <= ISSUE;
            busy  <= 1'b1;
            if (winner == OWN_CPU) begin
              we_q      <= cpu_we;
              addr_q    <= cpu_addr;
              wdata_q   <= cpu_wdata;
              ram_write <= cpu_we;
              cpu_gnt   <= 1'b1;
            end else begin
              we_q      <= ldr_we;
              addr_q    <= ldr_addr;
              wdata_q   <= ldr_wdata;
              ram_write <= ldr_we;
              ldr_gnt   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= WAIT;
            cpu_rvalid <= (owner == OWN_CPU);
            ldr_rvalid <= (owner == OWN_LDR);
          end
        end
        WAIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = addr_q;
  assign ram_din   = wdata_q;
  assign cpu_rdata = ram_dout;
  assign ldr_rdata = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a synchronous RAM model; read data expectations are queued per port.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy;

  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] shadow [0:255];
  logic          preloadEn;
  logic [AW-1:0] preloadAddr;
  logic [DW-1:0] preloadData;

  logic [DW-1:0] cpuQ[$];
  logic [DW-1:0] ldrQ[$];
  bit            gntOwnerLog[$];
  int            gntCycleLog[$];
  logic [DW-1:0] monExpCpu, monExpLdr;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int cpuGntCount = 0;
  int ldrGntCount = 0;
  int writeCycles = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ram_addr   (ram_addr),
    .ram_write  (ram_write),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .busy       (busy)
  );

  // Synchronous read-first RAM with a bench-only preload port.
  always @(posedge clk) begin
    if (preloadEn) ram[preloadAddr] <= preloadData;
    else if (ram_write) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Monitor: log grants, count write cycles, and pop the scoreboard on every rvalid.
  always @(negedge clk) begin
    if (reset) begin
      if (cpu_gnt) begin
        cpuGntCount++;
        gntOwnerLog.push_back(1'b0);
        gntCycleLog.push_back(cycle);
      end
      if (ldr_gnt) begin
        ldrGntCount++;
        gntOwnerLog.push_back(1'b1);
        gntCycleLog.push_back(cycle);
      end
      if (ram_write) writeCycles++;
      if (cpu_rvalid) begin
        if (cpuQ.size() == 0) checkOutput("cpu_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          monExpCpu = cpuQ.pop_front();
          checkOutput("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, monExpCpu});
        end
      end
      if (ldr_rvalid) begin
        if (ldrQ.size() == 0) checkOutput("ldr_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          monExpLdr = ldrQ.pop_front();
          checkOutput("ldr_rdata", {16'd0, ldr_rdata}, {16'd0, monExpLdr});
        end
      end
    end
  end

  // Drive one access on a port (0 = CPU, 1 = loader) and return at the negedge where gnt is seen.
  task automatic applyStimulus(input bit port, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input bit expectData, output int waited);
    bit granted;
    if (port == 1'b0) begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end else begin
      ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
    end
    if (we) shadow[addr] = wdata;
    else if (expectData) begin
      if (port == 1'b0) cpuQ.push_back(shadow[addr]);
      else ldrQ.push_back(shadow[addr]);
    end
    waited = 0;
    granted = 1'b0;
    while (!granted && waited < 40) begin
      @(negedge clk);
      waited++;
      granted = (port == 1'b0) ? cpu_gnt : ldr_gnt;
    end
    if (!granted) checkOutput(port ? "ldr_gnt_timeout" : "cpu_gnt_timeout", 32'd0, 32'd1);
    if (port == 1'b0) cpu_req = 1'b0;
    else ldr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int c0, l0, wc0;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    preloadEn = 1'b0; preloadAddr = '0; preloadData = '0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    checkOutput("rst_ldr_gnt", {31'd0, ldr_gnt}, 32'd0);
    checkOutput("rst_ram_write", {31'd0, ram_write}, 32'd0);
    checkOutput("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    checkOutput("rst_ram_din", {16'd0, ram_din}, 32'd0);

    preloadEn = 1'b1; preloadAddr = 8'h05; preloadData = 16'hBEEF; shadow[8'h05] = 16'hBEEF;
    @(negedge clk);
    preloadEn = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // CPU read of a preloaded word
    l0 = ldrGntCount;
    applyStimulus(1'b0, 1'b0, 8'h05, 16'h0, 1'b1, w);
    checkOutput("t1_gnt_latency", w, 32'd1);
    @(negedge clk);
    checkOutput("t1_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    checkOutput("t1_ldr_rvalid", {31'd0, ldr_rvalid}, 32'd0);
    checkOutput("t1_ldr_gnt_count", ldrGntCount - l0, 32'd0);

    // Loader write followed by CPU read-back
    @(negedge clk);
    wc0 = writeCycles;
    applyStimulus(1'b1, 1'b1, 8'h10, 16'h1234, 1'b0, w);
    checkOutput("t2_ram_write", {31'd0, ram_write}, 32'd1);
    checkOutput("t2_ram_addr", {24'd0, ram_addr}, 32'h10);
    checkOutput("t2_ram_din", {16'd0, ram_din}, 32'h1234);
    repeat (2) @(negedge clk);
    checkOutput("t2_write_cycles", writeCycles - wc0, 32'd1);
    checkOutput("t2_busy_idle", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h10, 16'h0, 1'b1, w);
    repeat (3) @(negedge clk);
    checkOutput("t2_cpuQ_drained", cpuQ.size(), 32'd0);

    // Both ports reading continuously from a fresh reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    gntOwnerLog.delete();
    fork
      begin : cpuStream
        int wc;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h05, 16'h0, 1'b1, wc);
      end
      begin : ldrStream
        int wl;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, wl);
      end
    join
    repeat (4) @(negedge clk);
    checkOutput("t3_gnt_total", gntOwnerLog.size(), 32'd8);
    for (int i = 0; i < 8 && i < gntOwnerLog.size(); i++) begin
`ifdef MEM_ARB_RR_EN
      checkOutput($sformatf("t3_gnt_order_%0d", i), {31'd0, gntOwnerLog[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
`else
      checkOutput($sformatf("t3_gnt_order_%0d", i), {31'd0, gntOwnerLog[i]}, (i >= 4) ? 32'd1 : 32'd0);
`endif
    end
    checkOutput("t3_queues_drained", cpuQ.size() + ldrQ.size(), 32'd0);

    // Reset during the WAIT cycle of a CPU read
    applyStimulus(1'b0, 1'b0, 8'h05, 16'h0, 1'b0, w);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("t4_busy_in_reset", {31'd0, busy}, 32'd0);
    checkOutput("t4_rvalid_in_reset", {31'd0, cpu_rvalid}, 32'd0);
    @(negedge clk);
    checkOutput("t4_rvalid_held", {31'd0, cpu_rvalid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h05, 16'h0, 1'b1, w);
    checkOutput("t4_fresh_gnt_latency", w, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("t4_cpuQ_drained", cpuQ.size(), 32'd0);

    // CPU req pulsed while the loader access is in ISSUE
    c0 = cpuGntCount;
    wc0 = writeCycles;
    fork
      begin : ldrSide
        int wl;
        applyStimulus(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, wl);
      end
      begin : cpuPulse
        int k;
        k = 0;
        while (!ldr_gnt && k < 10) begin
          @(negedge clk);
          k++;
        end
        cpu_we = 1'b1; cpu_addr = 8'h22; cpu_wdata = 16'hDEAD; cpu_req = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    checkOutput("t5_no_cpu_gnt", cpuGntCount - c0, 32'd0);
    checkOutput("t5_no_write", writeCycles - wc0, 32'd0);
    checkOutput("t5_ram22_untouched", {16'd0, ram[8'h22]}, 32'd0);
    checkOutput("t5_ldrQ_drained", ldrQ.size(), 32'd0);

    // Back-to-back CPU writes then read-back
    gntCycleLog.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, AW'(i), 16'hA000 + 16'(i), 1'b0, w);
    repeat (3) @(negedge clk);
    checkOutput("t6_gnt_count", gntCycleLog.size(), 32'd4);
    for (int i = 1; i < 4 && i < gntCycleLog.size(); i++)
      checkOutput($sformatf("t6_gnt_spacing_%0d", i), gntCycleLog[i] - gntCycleLog[i-1], 32'd2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, AW'(i), 16'h0, 1'b1, w);
    repeat (3) @(negedge clk);
    checkOutput("t6_cpuQ_drained", cpuQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single synchronous RAM port between the CPU controller (instruction fetch, LDR, STR) and the program loader, which writes program images into RAM before and between runs. It registers one request at a time, drives the RAM address/write/data lines, pulses a grant to the winner and returns read data with fixed latency. It sits between both requesters and the RAM; the CPU's `msel`/`mwrite` path is routed through it.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 16, RAM data width
- `clk` in 1 — single clock, all state on rising edge
- `reset` in 1 — asynchronous, active-low
- `cpu_req` in 1 — CPU access request, held until `cpu_gnt`
- `cpu_we` in 1 — 1 = write, 0 = read
- `cpu_addr` in ADDR_W — access address
- `cpu_wdata` in DATA_W — write data
- `cpu_gnt` out 1 — one-cycle pulse: CPU access issued to RAM
- `cpu_rvalid` out 1 — one-cycle pulse: `cpu_rdata` valid
- `cpu_rdata` out DATA_W — read data
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata` — loader port, identical semantics
- `ram_addr` out ADDR_W — RAM address
- `ram_write` out 1 — RAM write enable
- `ram_din` out DATA_W — RAM write data
- `ram_dout` in DATA_W — RAM read data, valid one cycle after address presented
- `busy` out 1 — FSM not in IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any `*_req` high at the clock edge, pick winner, latch its `we`/`addr`/`wdata` and owner, go to ISSUE; otherwise stay.
- ISSUE: `ram_addr` = latched addr; `ram_write` = latched we; `ram_din` = latched wdata; owner's `gnt` = 1. Write → IDLE. Read → WAIT.
- WAIT: owner's `rvalid` = 1; owner's `rdata` = `ram_dout`. → IDLE.
- `*_rdata` outputs are `ram_dout` for both ports; valid only while that port's `rvalid` is high.
- Requester protocol: hold `req` and payload stable until `gnt` is sampled high, then drop `req` on that edge. A request dropped before grant while in IDLE is simply not seen. Once latched, an access completes regardless of `req`.
- Tie (both requesting in IDLE): resolved per Configuration. A single requester always wins.
- Outputs outside ISSUE/WAIT: `ram_write` = 0, all `gnt`/`rvalid` = 0, `ram_addr`/`ram_din` = latched values.
- Reset (asserted any time, including mid-access): state → IDLE, `ram_write`, `gnt`, `rvalid`, `busy` → 0 immediately; latched addr/data → 0; RR pointer → "loader last". An interrupted read produces no `rvalid`. A write whose ISSUE cycle was cut short is undefined in RAM.

## Timing
- `req` sampled at edge N → `gnt` high in cycle N+1 (ISSUE) → read data with `rvalid` in cycle N+2.
- Write occupancy: 2 cycles (IDLE + ISSUE). Read occupancy: 3 cycles (IDLE + ISSUE + WAIT).
- There is no combinational path from `*_req` to any output. All outputs are decoded from registered state.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the port not granted most recently wins. The pointer updates on every IDLE→ISSUE transition.
- `MEM_ARB_RR_EN` undefined: fixed priority, CPU always wins a tie. The pointer logic is removed. The loader can starve while the CPU requests continuously.

## Structure
- Package `mem_arb_pkg`: state encoding (IDLE/ISSUE/WAIT) and owner constants (`OWN_CPU`, `OWN_LDR`).
- Sub-module `arb_pick`: combinational winner select from `cpu_req`, `ldr_req` and the last-owner pointer. Its body contains the `MEM_ARB_RR_EN` alternative.
- FSM, payload latch and output decode live in `mem_arbiter`.

## Test plan
- CPU read of addr 0x05, with RAM preloaded 0xBEEF → `cpu_gnt` one cycle after req sampled; `cpu_rvalid` with `cpu_rdata` = 0xBEEF the next cycle; loader outputs stay 0.
- Loader write of 0x1234 to addr 0x10, then CPU read of 0x10 → `ram_write` high exactly one cycle; CPU read returns 0x1234.
- Both ports request reads continuously, with RR enabled → grants alternate CPU, LDR, CPU, LDR; CPU first after reset. With RR disabled → CPU only.
- Reset asserted during WAIT of a CPU read → `cpu_rvalid` never pulses; `busy` = 0 immediately; a fresh request after release is granted normally.
- `cpu_req` pulsed for one cycle while the FSM is in ISSUE for the loader → request not latched, no `cpu_gnt`; the loader access completes unaffected.
- Back-to-back CPU writes to 0x00..0x03 → one `gnt` every 2 cycles; RAM holds all four values.
